// File: rtl/pipe_memory_if.sv
// Data-memory bus between the MEM-stage controller and memory.
// req/gnt request phase, rvalid/rdata response phase.
interface pipe_memory_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/pipe_memory.sv
// MEM-stage data-memory controller: bus sequencing, byte lanes,
// store forwarding from WB and load extension.
module pipe_memory #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_rd_M,
    input  logic                 mem_wr_M,
    input  logic [2:0]           mem_mask_M,
    input  logic [31:0]          alu_o_M,
    input  logic [31:0]          wr_data_M,
    input  logic [4:0]           rs2_addr_M,
    input  logic                 reg_wr_W,
    input  logic [4:0]           rd_W,
    input  logic [31:0]          wb_data_W,
    input  logic                 hold,
    pipe_memory_if.master        dmem,
    output logic [31:0]          load_data_M,
    output logic                 mem_stall,
    output logic                 misalign_M
);

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP, DONE} state_t;

    state_t      state;
    logic [1:0]  off_q;
    logic [2:0]  mask_q;
    logic [31:0] ldata_q;

    logic        is_b, is_h, is_w;
    logic        access, go, fwd_hit, rsp_now;
    logic [31:0] st_d, wd, sh, ext;
    logic [3:0]  be;

    assign is_b = (mem_mask_M[1:0] == 2'b00);
    assign is_h = (mem_mask_M[1:0] == 2'b01);
    assign is_w = mem_mask_M[1];

    assign misalign_M = (mem_rd_M | mem_wr_M) &
                        ((is_h & alu_o_M[0]) | (is_w & (|alu_o_M[1:0])));
    assign access = (mem_rd_M | mem_wr_M) & ~misalign_M;
    assign go     = access & ~rst & ((state == IDLE) | (state == WAIT_GNT));

    assign fwd_hit = FWD_EN & reg_wr_W & (rd_W != 5'd0) &
                     (rd_W == rs2_addr_M);
    assign st_d    = fwd_hit ? wb_data_W : wr_data_M;

    always_comb begin
        be = 4'b1111;
        wd = st_d;
        unique case (1'b1)
            is_b: begin
                be = 4'b0001 << alu_o_M[1:0];
                wd = {4{st_d[7:0]}};
            end
            is_h: begin
                be = alu_o_M[1] ? 4'b1100 : 4'b0011;
                wd = {2{st_d[15:0]}};
            end
            default: ;
        endcase
    end

    assign dmem.dmem_req   = go;
    assign dmem.dmem_we    = mem_wr_M;
    assign dmem.dmem_addr  = {alu_o_M[31:2], 2'b00};
    assign dmem.dmem_be    = be;
    assign dmem.dmem_wdata = wd;

    // Extension uses the offset/size latched at grant time.
    always_comb begin
        sh  = dmem.dmem_rdata >> {off_q, 3'b000};
        ext = sh;
        unique case (mask_q[1:0])
            2'b00:   ext = {{24{sh[7] & ~mask_q[2]}}, sh[7:0]};
            2'b01:   ext = {{16{sh[15] & ~mask_q[2]}}, sh[15:0]};
            default: ext = sh;
        endcase
    end

    assign rsp_now     = ~rst & (state == WAIT_RSP) & dmem.dmem_rvalid;
    assign load_data_M = rsp_now ? ext : ldata_q;

    always_comb begin
        mem_stall = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE, WAIT_GNT: mem_stall = go & ~(dmem.dmem_gnt & mem_wr_M);
                WAIT_RSP:       mem_stall = ~dmem.dmem_rvalid;
                DONE:           mem_stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            off_q   <= 2'b00;
            mask_q  <= 3'b000;
            ldata_q <= 32'h0;
        end else begin
            unique case (state)
                IDLE, WAIT_GNT: begin
                    if (!go) begin
                        state <= IDLE;
                    end else if (!dmem.dmem_gnt) begin
                        state <= WAIT_GNT;
                    end else if (!mem_wr_M) begin
                        state  <= WAIT_RSP;
                        off_q  <= alu_o_M[1:0];
                        mask_q <= mem_mask_M;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_RSP: begin
                    if (dmem.dmem_rvalid) begin
                        ldata_q <= ext;
                        state   <= hold ? DONE : IDLE;
                    end
                end
                DONE: begin
                    if (!hold) state <= IDLE;
                end
            endcase
        end
    end

endmodule
